// File: rtl/sig_pkg.sv
// Shared definitions for the sigmoid arbiter: Q7.8 data width, the default unit latency and the FSM state type.
package sig_pkg;

  localparam int DATA_W          = 16;
  localparam int DEFAULT_LATENCY = 9;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } state_t;

endpackage

// File: rtl/tag_delay.sv
// Fixed-depth delay line that carries request tags alongside the sigmoid unit's pipeline.
module tag_delay #(
  parameter int DEPTH = 9,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one pipelined sigmoid unit among NUM_REQ requesters and routes each result back to its owner.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin arbitration with lowest-index-first.
module sigmoid_arbiter
  import sig_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      drain,
  output logic                      sig_ena,
  output logic [DATA_W-1:0]         sig_in,
  input  logic                      sig_valid,
  input  logic [DATA_W-1:0]         sig_out,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      idle,
  output logic                      err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TAG_W = IDX_W + 1;
  localparam int CNT_W = $clog2(LATENCY + 2);

  state_t           state, state_nxt;
  logic             grant_any;
  logic             transfer;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] issue_idx;
  logic [TAG_W-1:0] exit_tag;
  logic             exit_valid;
  logic [IDX_W-1:0] exit_idx;
  logic [CNT_W-1:0] inflight;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end
`else
  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [SUM_W-1:0] probe;

  // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    probe     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = {1'b0, rr_ptr} + SUM_W'(k);
      if (probe >= SUM_W'(NUM_REQ)) probe = probe - SUM_W'(NUM_REQ);
      if (!grant_any && req_valid[probe[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = probe[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  // Grants are suppressed during reset and as soon as drain is requested.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == RUN && !drain && grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign transfer = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_ena   <= 1'b0;
      sig_in    <= '0;
      issue_idx <= '0;
    end else begin
      sig_ena <= transfer;
      if (transfer) begin
        sig_in    <= req_data[grant_idx*DATA_W +: DATA_W];
        issue_idx <= grant_idx;
      end
    end
  end

  tag_delay #(
    .DEPTH(LATENCY),
    .W    (TAG_W)
  ) u_tag_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({sig_ena, issue_idx}),
    .dout (exit_tag)
  );

  assign exit_valid = exit_tag[TAG_W-1];
  assign exit_idx   = exit_tag[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({sig_ena, exit_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign idle = (inflight == '0) && !sig_ena;

  // A result without a matching tag (or a tag without a result) is a protocol error and is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (sig_valid && exit_valid) begin
        rsp_valid[exit_idx] <= 1'b1;
        rsp_data            <= sig_out;
      end
      if (sig_valid != exit_valid) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0 && !exit_valid) state_nxt = HALT;
      HALT:    if (!drain) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Scoreboard bench for sigmoid_arbiter with a behavioural sigmoid unit (fixed latency, result = ~operand).
module tb_sigmoid_arbiter;

  localparam int N   = 4;
  localparam int LAT = 9;

  typedef struct {
    logic [3:0]  oh;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        drain;
  logic        sig_ena;
  logic [15:0] sig_in;
  logic        sig_valid;
  logic [15:0] sig_out;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        idle;
  logic        err;

  logic           inject;
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pd [LAT];

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 0;

  sigmoid_arbiter #(
    .NUM_REQ(N),
    .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .drain    (drain),
    .sig_ena  (sig_ena),
    .sig_in   (sig_in),
    .sig_valid(sig_valid),
    .sig_out  (sig_out),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .idle     (idle),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural sigmoid unit: not reset, so results already in flight survive a DUT reset.
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], sig_ena === 1'b1};
    pd[0] <= sig_in;
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end

  assign sig_valid = pv[LAT-1] | inject;
  assign sig_out   = ~pd[LAT-1];

  function automatic logic [15:0] expSig(input logic [15:0] x);
    return ~x;
  endfunction

  function automatic logic [63:0] mkData(input int k);
    logic [63:0] d;
    for (int i = 0; i < 4; i++) d[i*16 +: 16] = 16'h1000 + 16'(k*16 + i);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [63:0] d, input logic dr);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    drain     = dr;
    #1;
  endtask

  task automatic pushExp(input logic [3:0] oh, input logic [15:0] data, input int c);
    exp_t e;
    e.oh   = oh;
    e.data = data;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic waitIdle(input int maxCyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      #1;
      if (idle === 1'b1) seen = 1;
    end
    checkOutput("idle_wait", 32'(seen), 32'd1);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Monitor: every result strobe must match the oldest expected response, including its arrival cycle.
  always @(negedge clk) begin
    if (mon_en && rsp_valid !== 4'b0000) begin
      if (sbq.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("rsp_onehot", 32'(rsp_valid), 32'(mon_e.oh));
        checkOutput("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        checkOutput("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] d;
    logic [3:0]  expG;
    bit          found;
    int          g;
    int          c;

    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    drain     = 1'b0;
    inject    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_sig_ena", 32'(sig_ena), 32'd0);
    checkOutput("rst_sig_in", 32'(sig_in), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_idle", 32'(idle), 32'd1);
    mon_en = 1;

    // Single request from requester 2.
    applyStimulus(4'b0100, 64'h0000_0100_0000_0000, 1'b0);
    c = cyc;
    checkOutput("t1_ready", 32'(req_ready), 32'h4);
    pushExp(4'b0100, 16'hFEFF, c + 11);
    applyStimulus(4'b0000, 64'd0, 1'b0);
    checkOutput("t1_sig_ena", 32'(sig_ena), 32'd1);
    checkOutput("t1_sig_in", 32'(sig_in), 32'h0100);
    checkOutput("t1_busy", 32'(idle), 32'd0);
    waitIdle(20);

    // All four requesters valid from a fresh pointer: grants rotate 0,1,2,3.
    applyReset();
    for (int k = 0; k < 8; k++) begin
      d = mkData(k);
      g = k % 4;
      applyStimulus(4'b1111, d, 1'b0);
      checkOutput("t2_grant", 32'(req_ready), 32'(1 << g));
      pushExp(4'(1 << g), expSig(d[g*16 +: 16]), cyc + 11);
    end
    applyStimulus(4'b0000, 64'd0, 1'b0);
    waitIdle(25);

    // Continuous traffic then drain: no further issue, pipeline empties, resume after release.
    for (int k = 0; k < 5; k++) begin
      d = mkData(k + 8);
      applyStimulus(4'b0001, d, 1'b0);
      checkOutput("t3_grant", 32'(req_ready), 32'h1);
      pushExp(4'b0001, expSig(d[15:0]), cyc + 11);
    end
    applyStimulus(4'b0001, d, 1'b1);
    checkOutput("t3_drain_ready", 32'(req_ready), 32'd0);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      applyStimulus(4'b0001, d, 1'b1);
      checkOutput("t3_no_issue", 32'(sig_ena), 32'd0);
      checkOutput("t3_no_ready", 32'(req_ready), 32'd0);
      if (idle === 1'b1) found = 1;
    end
    checkOutput("t3_idle", 32'(found), 32'd1);
    repeat (2) applyStimulus(4'b0001, d, 1'b1);
    d = mkData(20);
    found = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      applyStimulus(4'b0001, d, 1'b0);
      if (req_ready !== 4'b0000) begin
        found = 1;
        checkOutput("t3_resume", 32'(req_ready), 32'h1);
        pushExp(4'b0001, expSig(d[15:0]), cyc + 11);
      end
    end
    checkOutput("t3_resumed", 32'(found), 32'd1);
    applyStimulus(4'b0000, 64'd0, 1'b0);
    waitIdle(25);

    // Reset with five operations in flight: late results must raise err and never strobe.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0010, mkData(k + 30), 1'b0);
      checkOutput("t4_grant", 32'(req_ready), 32'h2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    #1;
    checkOutput("t4_sig_ena", 32'(sig_ena), 32'd0);
    checkOutput("t4_sig_in", 32'(sig_in), 32'd0);
    checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t4_err_clear", 32'(err), 32'd0);
    checkOutput("t4_idle", 32'(idle), 32'd1);
    repeat (12) @(negedge clk);
    #1;
    checkOutput("t4_err_late", 32'(err), 32'd1);
    applyReset();
    checkOutput("t4_err_reset", 32'(err), 32'd0);

    // Requesters 1 and 3 held valid from pointer 0.
    for (int k = 0; k < 6; k++) begin
      d = mkData(k + 40);
`ifdef ARB_FIXED_PRIORITY_EN
      expG = 4'b0010;
`else
      expG = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      applyStimulus(4'b1010, d, 1'b0);
      checkOutput("t5_grant", 32'(req_ready), 32'(expG));
      pushExp(expG, expSig((expG == 4'b0010) ? d[31:16] : d[63:48]), cyc + 11);
    end
    applyStimulus(4'b0000, 64'd0, 1'b0);
    waitIdle(25);

    // Stray sigmoid result with an empty pipeline.
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    #1;
    checkOutput("t6_err", 32'(err), 32'd1);
    checkOutput("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_err_sticky", 32'(err), 32'd1);
    checkOutput("t6_idle", 32'(idle), 32'd1);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
